// File: rtl/outdisp_pkg.sv
// Shared definitions for the multiplexed 7-segment output display:
// display modes, conversion FSM states, segment glyphs and the BCD
// digit-count helper used to size the double-dabble converter.
package outdisp_pkg;

  // Display modes as captured from disp_mode (2'b11 behaves as hex).
  localparam logic [1:0] MODE_UDEC = 2'b00;
  localparam logic [1:0] MODE_SDEC = 2'b01;
  localparam logic [1:0] MODE_HEX  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Segment bits are {dp,g,f,e,d,c,b,a}, active-high; dp is never lit.
  localparam logic [7:0] GLYPH_MINUS = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [7:0] seg_glyph(input logic [3:0] d);
    return GLYPH_TABLE[d];
  endfunction

  // Decimal digits needed for 2**w-1: floor(w*log10(2))+1, with
  // log10(2) approximated by 1233/4096 (exact for all practical widths).
  function automatic int bcd_digits(input int w);
    return (w * 1233) / 4096 + 1;
  endfunction

endpackage

// File: rtl/outdisp_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per clock.
// start (re)loads the operand and restarts from step 0 even mid-run.
// last is high during the final step; done holds high from the end of
// the final step until the next start, while bcd carries the result.
module outdisp_bin2bcd
  import outdisp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NB    = bcd_digits(WIDTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [WIDTH-1:0]  din,
  output logic              last,
  output logic              done,
  output logic [4*NB-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q;
  logic [4*NB-1:0]  bcd_q;
  logic [4*NB-1:0]  bcd_adj;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             done_q;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD register per clock.
  always_ff @(posedge clk) begin
    if (clr) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      bin_q  <= din;
      bcd_q  <= '0;
      cnt_q  <= CW'(WIDTH);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      bcd_q <= {bcd_adj[4*NB-2:0], bin_q[WIDTH-1]};
      bin_q <= {bin_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign last = run_q && (cnt_q == CW'(1));
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/outdisplay_mux.sv
// Output register with multiplexed common-cathode 7-segment driver.
// oi captures bus/disp_mode and starts a WIDTH-cycle binary-to-BCD
// conversion; the display buffer changes only when a conversion commits,
// so a restart (oi while busy) or a clr never exposes partial digits.
// Build option: define OUTDISP_LZB_EN for leading-zero blanking.
module outdisplay_mux
  import outdisp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              oi,
  input  logic [WIDTH-1:0]  bus,
  input  logic [1:0]        disp_mode,
  output logic [DIGITS-1:0] cc,
  output logic [7:0]        anode,
  output logic              busy
);

  localparam int NB     = bcd_digits(WIDTH);
  localparam int NH     = (WIDTH + 3) / 4;
  localparam int MAXD_A = (NB > NH) ? NB : NH;
  localparam int MAXD   = (MAXD_A > DIGITS) ? MAXD_A : DIGITS;
  localparam int IDXW   = $clog2(DIGITS);
  localparam int PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           state_q;
  logic [WIDTH-1:0] value_q;
  logic [1:0]       mode_q;
  logic [7:0]       disp_q [DIGITS];
  logic [7:0]       disp_d [DIGITS];

  logic [WIDTH-1:0] load_mag;
  logic [4*NB-1:0]  bcd;
  logic             bcd_last;
  logic             bcd_done;

  logic             neg;
  logic             is_hex;
  logic             ovf;
  logic [4*MAXD-1:0] bcd_pad;
  logic [4*MAXD-1:0] hex_pad;
  logic [3:0]       dv [DIGITS];

  logic [PW-1:0]    pre_q;
  logic [IDXW-1:0]  idx_q;
  logic [IDXW-1:0]  cur_q;
  logic             scan_on_q;
  logic             scan_tc;

  // A negative signed load converts its two's-complement magnitude, which
  // is exact as an unsigned WIDTH-bit value even for the most negative input.
  assign load_mag = (disp_mode == MODE_SDEC && bus[WIDTH-1]) ? (~bus + WIDTH'(1)) : bus;

  outdisp_bin2bcd #(
    .WIDTH (WIDTH),
    .NB    (NB)
  ) u_bin2bcd (
    .clk   (clk),
    .clr   (clr),
    .start (oi),
    .din   (load_mag),
    .last  (bcd_last),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // Per-digit values and overflow for the captured value and mode.
  always_comb begin
    neg     = (mode_q == MODE_SDEC) && value_q[WIDTH-1];
    is_hex  = (mode_q & MODE_HEX) != 2'b00;
    bcd_pad = '0;
    bcd_pad[4*NB-1:0] = bcd;
    hex_pad = '0;
    hex_pad[WIDTH-1:0] = value_q;
    ovf = 1'b0;
    for (int j = 0; j < MAXD; j++) begin
      if (is_hex) begin
        if (j >= DIGITS && hex_pad[4*j +: 4] != 4'd0) ovf = 1'b1;
      end else begin
        if (j >= (neg ? DIGITS - 1 : DIGITS) && bcd_pad[4*j +: 4] != 4'd0) ovf = 1'b1;
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      dv[i] = is_hex ? hex_pad[4*i +: 4] : bcd_pad[4*i +: 4];
    end
  end

`ifdef OUTDISP_LZB_EN
  logic seen;
`endif

  // Glyph for every digit position, scanning from the most significant down.
  always_comb begin
`ifdef OUTDISP_LZB_EN
    seen = 1'b0;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf) begin
        disp_d[i] = GLYPH_MINUS;
      end else if (neg && i == DIGITS - 1) begin
        disp_d[i] = GLYPH_MINUS;
      end else begin
`ifdef OUTDISP_LZB_EN
        if (dv[i] != 4'd0 || i == 0) seen = 1'b1;
        disp_d[i] = seen ? seg_glyph(dv[i]) : GLYPH_BLANK;
`else
        disp_d[i] = seg_glyph(dv[i]);
`endif
      end
    end
  end

  // Capture/convert/commit FSM; oi restarts from any state, latest load wins.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      value_q <= '0;
      mode_q  <= MODE_UDEC;
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= seg_glyph(4'd0);
    end else if (oi) begin
      value_q <= bus;
      mode_q  <= disp_mode;
      state_q <= CONV;
      busy    <= 1'b1;
    end else begin
      case (state_q)
        CONV: begin
          if (bcd_last) state_q <= COMMIT;
        end
        COMMIT: begin
          if (bcd_done) begin
            for (int i = 0; i < DIGITS; i++) disp_q[i] <= disp_d[i];
          end
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan_tc = (pre_q == PW'(SCAN_DIV - 1));

  // Digit scan: advance the selected digit at each prescaler terminal count;
  // the anode keeps tracking the buffer for the digit currently selected.
  always_ff @(posedge clk) begin
    if (clr) begin
      pre_q     <= '0;
      idx_q     <= '0;
      cur_q     <= '0;
      scan_on_q <= 1'b0;
      cc        <= '1;
      anode     <= '0;
    end else if (scan_tc) begin
      pre_q     <= '0;
      cc        <= ~(DIGITS'(1) << idx_q);
      anode     <= disp_q[idx_q];
      cur_q     <= idx_q;
      idx_q     <= (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
      scan_on_q <= 1'b1;
    end else begin
      pre_q <= pre_q + PW'(1);
      if (scan_on_q) anode <= disp_q[cur_q];
    end
  end

endmodule
